l1c_data_assoc: RTL and testbench

L1C_DATA_ASSOC -- requirements
Module: l1c_data_assoc

---
 rtl/l1c_data_assoc_if.sv | 40 ++++
 rtl/l1c_data_assoc.sv | 213 +++++++++++++++++++++
 tb/tb_l1c_data_assoc.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1c_data_assoc_if.sv
// Core-side and memory-side signal bundle for the l1c_data_assoc cache.
// The cache uses the slave modport. The core/memory environment uses master.
interface l1c_data_assoc_if;
  // core side
  logic        core_req;
  logic        core_write;
  logic [3:0]  core_wstrb;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall_in;
  logic        inv_all;
  logic [31:0] core_rdata;
  logic        core_wait;
  // memory side
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rlast;
  logic        mem_bvalid;

  modport slave (
    input  core_req, core_write, core_wstrb, core_addr, core_wdata,
    input  core_stall_in, inv_all,
    output core_rdata, core_wait,
    output mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_rvalid, mem_rlast, mem_bvalid
  );

  modport master (
    output core_req, core_write, core_wstrb, core_addr, core_wdata,
    output core_stall_in, inv_all,
    input  core_rdata, core_wait,
    input  mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_rvalid, mem_rlast, mem_bvalid
  );
endinterface

// File: rtl/l1c_data_assoc.sv
// Set-associative L1 data cache with write-through, no-write-allocate stores.
// Tags, valid bits and line data live in flop arrays. Victims are chosen as
// the lowest invalid way, or else a per-set round-robin pointer.
// Optional hit/miss counters are enabled with the L1C_DATA_PERF_CNT_EN macro.
module l1c_data_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 32 - $clog2(SETS) - $clog2(LINE_WORDS) - 2
) (
  input  logic                clk,
  input  logic                rst,
  l1c_data_assoc_if.slave     bus
`ifdef L1C_DATA_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        wstrb_q;
  logic              write_q;
  logic              first_q;        // first WRITE cycle, when a store hit updates the line
  logic [WORD_W-1:0] beat_q;
  logic [WAY_W-1:0]  victim_q;
  logic              victim_valid_q; // refill replaces a valid line, so round-robin advances

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][LINE_WORDS];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              victim_found;
  logic [WAY_W-1:0]  victim;
  logic              accept;
  logic              beat;
  logic              last_beat;

  assign tag       = addr_q[31 -: TAG_W];
  assign idx       = addr_q[OFF_W +: IDX_W];
  assign word      = addr_q[2 +: WORD_W];
  assign accept    = (state_q == S_IDLE) && bus.core_req && !bus.core_stall_in;
  assign beat      = (state_q == S_REFILL) && bus.mem_rvalid;
  assign last_beat = beat && bus.mem_rlast;

  // Tag match across ways and victim choice for the captured address.
  // NOTE: every variable gets a default before any branch, so this stays
  // combinational and no latch is inferred.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_found = 1'b0;
    victim       = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!victim_found && !valid_q[idx][w]) begin
        victim_found = 1'b1;
        victim       = WAY_W'(w);
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = bus.core_write ? S_WRITE : S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_IDLE : S_REFILL;
      S_REFILL: if (last_beat) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      S_WRITE:  if (bus.mem_bvalid) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Core and memory outputs decoded from the state. During reset the FSM
  // sits in IDLE, and core_wait is held low so that every output reads 0.
  always_comb begin
    bus.core_rdata = '0;
    bus.core_wait  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wstrb  = '0;
    case (state_q)
      S_IDLE:   bus.core_wait = bus.core_req && !rst;
      S_LOOKUP: begin
        bus.core_wait = !hit;
        if (hit) bus.core_rdata = data_q[hit_way][idx][word];
      end
      S_REFILL: begin
        bus.core_wait = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
      end
      S_RESP:   bus.core_rdata = data_q[victim_q][idx][word];
      S_WRITE:  begin
        bus.core_wait = !bus.mem_bvalid;
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = wstrb_q;
      end
      default: ;
    endcase
  end

  // FSM state, request capture, victim latch and refill beat counter.
  // NOTE: sequential state is updated only with non-blocking assignments,
  // so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      write_q        <= 1'b0;
      first_q        <= 1'b0;
      beat_q         <= '0;
      victim_q       <= '0;
      victim_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.core_addr;
        wdata_q <= bus.core_wdata;
        wstrb_q <= bus.core_wstrb;
        write_q <= bus.core_write;
        first_q <= bus.core_write;
      end else if (state_q == S_WRITE) begin
        first_q <= 1'b0;
      end
      if ((state_q == S_LOOKUP) && !hit && !write_q) begin
        victim_q       <= victim;
        victim_valid_q <= !victim_found;
        beat_q         <= '0;
      end else if (beat && (beat_q != LAST_WORD)) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Valid bits and round-robin pointers. A flash invalidate takes priority
  // over the valid set of a coincident final refill beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (bus.inv_all) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (last_beat) begin
        valid_q[idx][victim_q] <= 1'b1;
      end
      if (last_beat && victim_valid_q)
        rr_q[idx] <= (rr_q[idx] == LAST_WAY) ? '0 : rr_q[idx] + 1'b1;
    end
  end

  // Tag and data storage: refill beats, refill tag, store-hit byte merge.
  // NOTE: the storage arrays have no reset. The valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (beat) data_q[victim_q][idx][beat_q] <= bus.mem_rdata;
    if (last_beat) tag_q[victim_q][idx] <= tag;
    if ((state_q == S_WRITE) && first_q && hit) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) data_q[hit_way][idx][word][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

`ifdef L1C_DATA_PERF_CNT_EN
  // Wrapping hit/miss counters, one step per load lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1c_data_assoc.sv
// Scoreboard bench for l1c_data_assoc. The driver issues directed accesses and
// queues the hand-computed responses. A core monitor and a memory model pop
// those queues and compare them whenever the DUT completes or requests memory.
module tb_l1c_data_assoc;

  localparam int LW = 4;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    string       name;
  } core_exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_exp_t;

  logic clk;
  logic rst;
  l1c_data_assoc_if bus ();
`ifdef L1C_DATA_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  l1c_data_assoc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef L1C_DATA_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  core_exp_t   core_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] wmem [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          inv_req = 0;
  int          inv_done = 0;
  bit          hold_refill = 1'b0;
  bit          inv_on_last = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Backing memory: written words override a fixed pattern.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (wmem.exists(w)) return wmem[w];
    if (w[31:4] == 28'h0000010) return 32'h0000_00A0 + 32'(w[3:2]);
    return {8'hC0, w[23:0]};
  endfunction

  task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb);
    mem_exp_t me;
    me.write = wr;
    me.addr  = wr ? addr : {addr[31:4], 4'h0};
    me.wdata = wr ? wd : 32'h0;
    me.wstrb = wr ? strb : 4'h0;
    mem_q.push_back(me);
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input int exp_lat,
                        input logic exp_mem, input int stall, input string nm);
    core_exp_t ce;
    bit done;
    ce.rdata = exp_rdata;
    ce.lat   = exp_lat;
    ce.name  = nm;
    core_q.push_back(ce);
    if (exp_mem) push_mem(wr, addr, wd, strb);
    @(posedge clk); #1;
    bus.core_req      = 1'b1;
    bus.core_write    = wr;
    bus.core_addr     = addr;
    bus.core_wdata    = wd;
    bus.core_wstrb    = strb;
    bus.core_stall_in = (stall > 0);
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        check({nm, " stalled core_wait"}, 32'(bus.core_wait), 32'd1);
      end
      bus.core_stall_in = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!bus.core_wait) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_completion required=completion", nm);
    end
    @(posedge clk); #1;
    bus.core_req   = 1'b0;
    bus.core_write = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.core_wstrb = '0;
  endtask

  // Core monitor: a completion is core_req=1 with core_wait=0.
  initial begin
    core_exp_t e;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (rst || !bus.core_req) begin
        cyc = 0;
      end else begin
        cyc++;
        if (!bus.core_wait) begin
          if (core_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected completion actual=0x%08h required=none", bus.core_rdata);
          end else begin
            e = core_q.pop_front();
            check({e.name, " rdata"}, bus.core_rdata, e.rdata);
            if (e.lat > 0) check({e.name, " latency"}, 32'(cyc), 32'(e.lat));
          end
          cyc = 0;
        end
      end
    end
  end

  // Memory model: checks each new request against the queue, then serves it.
  initial begin
    mem_exp_t    me;
    logic [31:0] a, w;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    bus.mem_bvalid = 1'b0;
    bus.inv_all    = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) continue;
      if (inv_done != inv_req) begin
        bus.inv_all = 1'b1;
        @(posedge clk); #1;
        bus.inv_all = 1'b0;
        inv_done++;
      end else if (bus.mem_req) begin
        a = bus.mem_addr;
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected mem_req actual=0x%08h required=none", a);
        end else begin
          me = mem_q.pop_front();
          check("mem_write", 32'(bus.mem_write), 32'(me.write));
          check("mem_addr", a, me.addr);
          if (me.write) begin
            check("mem_wdata", bus.mem_wdata, me.wdata);
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(me.wstrb));
          end
        end
        if (bus.mem_write) begin
          w = rd_word(a);
          for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
          @(posedge clk); #1;
          check("mem_req held for write", 32'(bus.mem_req), 32'd1);
          wmem[{a[31:2], 2'b00}] = w;
          bus.mem_bvalid = 1'b1;
          @(posedge clk); #1;
          bus.mem_bvalid = 1'b0;
        end else if (hold_refill) begin
          for (int i = 0; i < 30 && bus.mem_req; i++) @(negedge clk);
        end else begin
          for (int i = 0; i < LW; i++) begin
            check("mem_req held for refill", 32'(bus.mem_req), 32'd1);
            bus.mem_rdata  = rd_word(a + 32'(4 * i));
            bus.mem_rvalid = 1'b1;
            bus.mem_rlast  = (i == LW - 1);
            bus.inv_all    = (i == LW - 1) && inv_on_last;
            @(posedge clk); #1;
          end
          bus.mem_rvalid = 1'b0;
          bus.mem_rlast  = 1'b0;
          bus.mem_rdata  = '0;
          bus.inv_all    = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit done;
    rst               = 1'b1;
    bus.core_req      = 1'b0;
    bus.core_write    = 1'b0;
    bus.core_wstrb    = '0;
    bus.core_addr     = '0;
    bus.core_wdata    = '0;
    bus.core_stall_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset core_wait", 32'(bus.core_wait), 32'd0);
    check("reset core_rdata", bus.core_rdata, 32'd0);
    check("reset mem_req", 32'(bus.mem_req), 32'd0);
    check("reset mem_write", 32'(bus.mem_write), 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    check("reset mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    rst = 1'b0;

    // cold miss, hits, store hit with partial strobes
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_00A1, -1, 1'b1, 0, "cold load 104");
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_00A1, 2, 1'b0, 0, "hit load 104");
    access(1'b0, 32'h0000_010C, 32'h0, 4'h0, 32'h0000_00A3, 2, 1'b0, 0, "hit load 10c");
    access(1'b1, 32'h0000_0104, 32'hFFFF_BEEF, 4'b0011, 32'h0, -1, 1'b1, 0, "store hit 104");
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_BEEF, 2, 1'b0, 0, "reload 104");

    // store miss leaves the cache untouched; the next load must refill
    access(1'b1, 32'h0000_3054, 32'h1234_5678, 4'hF, 32'h0, -1, 1'b1, 0, "store miss 3054");
    access(1'b0, 32'h0000_3054, 32'h0, 4'h0, 32'h1234_5678, -1, 1'b1, 0, "load after store miss");

    // sibling stall holds the request in IDLE
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_BEEF, 4, 1'b0, 3, "stalled hit 104");

    // set 0 replacement: invalid ways first, then round-robin
    access(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hC000_0000, -1, 1'b1, 0, "fill 000");
    access(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'hC000_0400, -1, 1'b1, 0, "fill 400");
    access(1'b0, 32'h0000_0800, 32'h0, 4'h0, 32'hC000_0800, -1, 1'b1, 0, "fill 800 evict way0");
    access(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'hC000_0400, 2, 1'b0, 0, "hit 400");
    access(1'b0, 32'h0000_0800, 32'h0, 4'h0, 32'hC000_0800, 2, 1'b0, 0, "hit 800");
    access(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hC000_0000, -1, 1'b1, 0, "miss 000 evict way1");
    access(1'b0, 32'h0000_0800, 32'h0, 4'h0, 32'hC000_0800, 2, 1'b0, 0, "hit 800 again");
    access(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'hC000_0400, -1, 1'b1, 0, "miss 400 evicted");

    // flash invalidate while idle
    inv_req++;
    for (int i = 0; i < 20 && inv_done != inv_req; i++) @(posedge clk);
    check("inv_all pulse issued", 32'(inv_done), 32'(inv_req));
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_BEEF, -1, 1'b1, 0, "miss 104 after inv");

    // invalidate coincident with the final refill beat
    inv_on_last = 1'b1;
    access(1'b0, 32'h0000_3058, 32'h0, 4'h0, 32'hC000_3058, -1, 1'b1, 0, "refill 3058 inv on last");
    inv_on_last = 1'b0;
    access(1'b0, 32'h0000_3058, 32'h0, 4'h0, 32'hC000_3058, -1, 1'b1, 0, "miss 3058 valid suppressed");
    access(1'b0, 32'h0000_3058, 32'h0, 4'h0, 32'hC000_3058, 2, 1'b0, 0, "hit 3058");

    // asynchronous reset in the middle of a refill
    hold_refill = 1'b1;
    push_mem(1'b0, 32'h0000_0304, 32'h0, 4'h0);
    @(posedge clk); #1;
    bus.core_req   = 1'b1;
    bus.core_write = 1'b0;
    bus.core_addr  = 32'h0000_0304;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_req) done = 1'b1;
    end
    check("refill started before reset", 32'(done), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst mid-refill mem_req", 32'(bus.mem_req), 32'd0);
    check("rst mid-refill mem_addr", bus.mem_addr, 32'd0);
    check("rst mid-refill core_wait", 32'(bus.core_wait), 32'd0);
    check("rst mid-refill core_rdata", bus.core_rdata, 32'd0);
    bus.core_req  = 1'b0;
    bus.core_addr = '0;
    @(negedge clk);
    rst = 1'b0;
    hold_refill = 1'b0;
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_BEEF, -1, 1'b1, 0, "miss 104 after reset");
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_BEEF, 2, 1'b0, 0, "hit 104 after reset");

    repeat (4) @(posedge clk);
    check("core scoreboard drained", 32'(core_q.size()), 32'd0);
    check("mem scoreboard drained", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
